// File: rtl/sound_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sound_write_sequencer                                      |
// | Description : Queues CPU sound-chip writes in a small FIFO and replays   |
// |               each byte to the SN76489-style Sound_Generator as a        |
// |               setup / nWE strobe / hold sequence timed in clk_en ticks.  |
// | Options     : SOUND_INIT_MUTE_EN - when defined, the sequencer mutes all |
// |               four channels (9F, BF, DF, FF) after reset before it       |
// |               services the FIFO.                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sound_write_sequencer #(
   parameter int DEPTH     = 4,
   parameter int WE_TICKS  = 8,
   parameter int GAP_TICKS = 2
) (
   input  logic       clk,
   input  logic       nRESET,
   input  logic       clk_en,
   input  logic       wr_req,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       busy,
   output logic       overflow,
   output logic [7:0] DATA,
   output logic       nWE
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int MAXT = (WE_TICKS > GAP_TICKS) ? WE_TICKS : GAP_TICKS;
   localparam int CNTW = (MAXT > 1) ? $clog2(MAXT) : 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3
`ifdef SOUND_INIT_MUTE_EN
      ,
      ST_INIT   = 3'd4
`endif
   } state_t;

`ifdef SOUND_INIT_MUTE_EN
   localparam state_t RESET_STATE = ST_INIT;
`else
   localparam state_t RESET_STATE = ST_IDLE;
`endif

   // FIFO storage and bookkeeping
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      w_head;
   logic            w_pop_req;
   logic            w_pop;
   logic            w_push;

   // Sequencer state
   state_t          r_state;
   state_t          w_state_nxt;
   logic [CNTW-1:0] r_counter;
   logic [CNTW-1:0] w_counter_nxt;
   logic [7:0]      w_data_nxt;
   logic            w_nwe_nxt;

`ifdef SOUND_INIT_MUTE_EN
   logic [1:0]      r_init_idx;
   logic [1:0]      w_init_idx_nxt;
   logic            r_init_active;
   logic            w_init_active_nxt;
   logic [7:0]      w_init_byte;

   // Latch byte 1,cc,1,1111: attenuation 15 on channel cc
   assign w_init_byte = {1'b1, r_init_idx, 5'b11111};
`endif

   assign w_head   = r_mem[r_rd_ptr];
   assign w_pop    = clk_en & w_pop_req;
   // A full FIFO still accepts a byte when the head leaves on the same tick
   assign w_push   = clk_en & wr_req & ((r_count != CW'(DEPTH)) | w_pop);
   assign full     = (r_count == CW'(DEPTH));
   assign busy     = (r_state != ST_IDLE) | (r_count != '0);

   // FIFO payload store; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         overflow <= 1'b0;
      end else if (clk_en) begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (wr_req && !w_push) begin
            overflow <= 1'b1;
         end
      end
   end

   // Sequencer registers, including the registered DATA/nWE outputs
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         r_state   <= RESET_STATE;
         r_counter <= '0;
         DATA      <= 8'h00;
         nWE       <= 1'b1;
`ifdef SOUND_INIT_MUTE_EN
         r_init_idx    <= 2'd0;
         r_init_active <= 1'b1;
`endif
      end else if (clk_en) begin
         r_state   <= w_state_nxt;
         r_counter <= w_counter_nxt;
         DATA      <= w_data_nxt;
         nWE       <= w_nwe_nxt;
`ifdef SOUND_INIT_MUTE_EN
         r_init_idx    <= w_init_idx_nxt;
         r_init_active <= w_init_active_nxt;
`endif
      end
   end

   // Next-state, counter and output decode for the setup/strobe/hold sequence
   always_comb begin
      w_state_nxt   = r_state;
      w_counter_nxt = r_counter;
      w_data_nxt    = DATA;
      w_nwe_nxt     = nWE;
      w_pop_req     = 1'b0;
`ifdef SOUND_INIT_MUTE_EN
      w_init_idx_nxt    = r_init_idx;
      w_init_active_nxt = r_init_active;
`endif
      case (r_state)
         ST_IDLE: begin
            w_nwe_nxt = 1'b1;
            if (r_count != '0) begin
               w_pop_req     = 1'b1;
               w_data_nxt    = w_head;
               w_counter_nxt = '0;
               w_state_nxt   = ST_SETUP;
            end
         end
`ifdef SOUND_INIT_MUTE_EN
         ST_INIT: begin
            w_nwe_nxt     = 1'b1;
            w_data_nxt    = w_init_byte;
            w_counter_nxt = '0;
            w_state_nxt   = ST_SETUP;
         end
`endif
         ST_SETUP: begin
            w_nwe_nxt     = 1'b0;
            w_counter_nxt = '0;
            w_state_nxt   = ST_STROBE;
         end
         ST_STROBE: begin
            w_nwe_nxt = 1'b0;
            if (r_counter == CNTW'(WE_TICKS - 1)) begin
               w_nwe_nxt     = 1'b1;
               w_counter_nxt = '0;
               w_state_nxt   = ST_HOLD;
            end else begin
               w_counter_nxt = r_counter + CNTW'(1);
            end
         end
         ST_HOLD: begin
            w_nwe_nxt = 1'b1;
            if (r_counter == CNTW'(GAP_TICKS - 1)) begin
               w_counter_nxt = '0;
               w_state_nxt   = ST_IDLE;
`ifdef SOUND_INIT_MUTE_EN
               if (r_init_active) begin
                  if (r_init_idx == 2'd3) begin
                     w_init_active_nxt = 1'b0;
                  end else begin
                     w_init_idx_nxt = r_init_idx + 2'd1;
                     w_state_nxt    = ST_INIT;
                  end
               end
`endif
            end else begin
               w_counter_nxt = r_counter + CNTW'(1);
            end
         end
         default: begin
            w_nwe_nxt     = 1'b1;
            w_counter_nxt = '0;
            w_state_nxt   = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
